// File: rtl/lsu_pkg.sv
// Shared types and constants for the load-store unit: FSM states,
// func3 width/sign codes and byte-strobe patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] STRB_NONE = 4'h0;
  localparam logic [3:0] STRB_B    = 4'h1;
  localparam logic [3:0] STRB_H    = 4'h3;
  localparam logic [3:0] STRB_W    = 4'hF;

  // Unshifted strobe for a store of the given size code (func3[1:0]).
  function automatic logic [3:0] base_strb(input logic [1:0] size);
    case (size)
      2'd0:    base_strb = STRB_B;
      2'd1:    base_strb = STRB_H;
      default: base_strb = STRB_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store steering/strobes and legality check on the
// live request, load extraction/extension on the captured request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_en,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        illegal,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Legality: size/alignment, unknown codes, unsigned stores, and a
  // request that is not exactly one of load/store.
  always_comb begin
    illegal = 1'b0;
    case (func3)
      F3_B, F3_BU: illegal = 1'b0;
      F3_H, F3_HU: illegal = off[0];
      F3_W:        illegal = (off != 2'b00);
      default:     illegal = 1'b1;
    endcase
    if (is_store && func3[2]) illegal = 1'b1;
    if (is_load == is_store)  illegal = 1'b1;
    if (!mem_en)              illegal = 1'b0;
  end

  // Each byte lane takes the replicated byte, replicated half, or own byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_wdata[8*gi +: 8] =
      (func3[1:0] == 2'd0) ? wdata[7:0] :
      (func3[1:0] == 2'd1) ? wdata[8*(gi%2) +: 8] :
                             wdata[8*gi +: 8];
  end

  // Strobes only for stores; loads present an all-zero strobe.
  always_comb begin
    st_wstrb = STRB_NONE;
    if (is_store) st_wstrb = base_strb(func3[1:0]) << off;
  end

  // Select the addressed byte and half from the returned word.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign or zero extension according to the captured width code.
  always_comb begin
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load-store unit: IDLE/WAIT/DONE transaction FSM, registered memory
// request fields, and the registered load result for writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic          is_mem_load,
  input  logic          is_mem_store,
  input  logic [2:0]    func3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] load_data,
  output logic          load_valid,
  output logic          mem_err,
  lsu_if.master         dmem
);

  state_t        state_reg, state_next;
  logic          capture, complete;
  logic          illegal;
  logic [31:0]   st_wdata, ld_data;
  logic [3:0]    st_wstrb;

  logic          req_reg, we_reg, is_load_reg, load_valid_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg, load_data_reg;
  logic [3:0]    wstrb_reg;
  logic [2:0]    func3_reg;
  logic [1:0]    off_reg;

  lsu_align u_align (
    .mem_en   (mem_en),
    .is_load  (is_mem_load),
    .is_store (is_mem_store),
    .func3    (func3),
    .off      (addr[1:0]),
    .wdata    (wdata),
    .illegal  (illegal),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_func3 (func3_reg),
    .ld_off   (off_reg),
    .rdata    (dmem.rdata),
    .ld_data  (ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state plus combinational stall / error / capture strobes.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    mem_err    = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_en) begin
          if (illegal) begin
            mem_err = 1'b1;
          end else begin
            stall      = 1'b1;
            capture    = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dmem.ack) begin
          complete   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are loaded at capture and held until ack; load result
  // is registered on ack and held until the next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= STRB_NONE;
      func3_reg      <= F3_B;
      off_reg        <= 2'b00;
      is_load_reg    <= 1'b0;
      load_data_reg  <= '0;
      load_valid_reg <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      if (capture) begin
        req_reg     <= 1'b1;
        we_reg      <= is_mem_store;
        addr_reg    <= {addr[AW-1:2], 2'b00};
        wdata_reg   <= st_wdata;
        wstrb_reg   <= st_wstrb;
        func3_reg   <= func3;
        off_reg     <= addr[1:0];
        is_load_reg <= is_mem_load;
      end
      if (complete) begin
        req_reg <= 1'b0;
        if (is_load_reg) begin
          load_data_reg  <= ld_data;
          load_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign dmem.req   = req_reg;
  assign dmem.we    = we_reg;
  assign dmem.addr  = addr_reg;
  assign dmem.wdata = wdata_reg;
  assign dmem.wstrb = wstrb_reg;
  assign load_data  = load_data_reg;
  assign load_valid = load_valid_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for the load-store unit.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  waits;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_load;
  } vec_t;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, is_mem_load, is_mem_store;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, mem_err;
  logic [31:0] load_data;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load;
  vec_t        vecs [NV];

  lsu_if #(.AW(32), .DW(32)) dm ();

  lsu #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .is_mem_load  (is_mem_load),
    .is_mem_store (is_mem_store),
    .func3        (func3),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .mem_err      (mem_err),
    .dmem         (dm.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Drives one instruction from a negedge, plays memory with v.waits wait
  // cycles, and checks stall/req counts, request fields and the load result.
  task automatic run_txn(input int idx, input vec_t v);
    int          stall_n = 0;
    int          req_n = 0;
    int          lv_n = 0;
    int          cyc = 0;
    bit          err_seen = 0;
    bit          seen_stall = 0;
    bit          finished = 0;
    logic [31:0] exp_ld;
    exp_ld = (v.is_load && !v.exp_err) ? v.exp_load : last_load;
    mem_en = 1'b1; is_mem_load = v.is_load; is_mem_store = v.is_store;
    func3 = v.func3; addr = v.addr; wdata = v.wdata;
    dm.ack = 1'b0; dm.rdata = v.rdata;
    while (!finished && cyc < 30) begin
      #1;
      if (stall) stall_n++;
      if (mem_err) err_seen = 1'b1;
      if (load_valid) begin
        lv_n++;
        chk("load_data_valid", load_data, exp_ld);
      end
      if (dm.req) begin
        req_n++;
        chk("req_addr", dm.addr, v.exp_addr);
        chk("req_we", {31'b0, dm.we}, {31'b0, v.is_store});
        chk("req_wstrb", {28'b0, dm.wstrb}, {28'b0, v.exp_wstrb});
        if (v.is_store) chk("req_wdata", dm.wdata, v.exp_wdata);
        dm.ack = (req_n > int'(v.waits));
      end else begin
        dm.ack = 1'b0;
      end
      if (stall) seen_stall = 1'b1;
      else if (seen_stall || (v.exp_err && cyc >= 3)) finished = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!finished) chk("txn_timeout", 32'd0, 32'd1);
    chk("mem_err", {31'b0, err_seen}, {31'b0, v.exp_err});
    chk("stall_cycles", stall_n, v.exp_err ? 0 : int'(v.waits) + 2);
    chk("req_cycles", req_n, v.exp_err ? 0 : int'(v.waits) + 1);
    chk("load_valid_cycles", lv_n, (v.is_load && !v.exp_err) ? 1 : 0);
    // Back in IDLE: drop the instruction and offer a stray ack.
    mem_en = 1'b0; dm.ack = 1'b1; dm.rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("idle_req", {31'b0, dm.req}, 32'd0);
    @(negedge clk);
    dm.ack = 1'b0;
    #1;
    chk("idle_load_valid", {31'b0, load_valid}, 32'd0);
    chk("load_data_hold", load_data, exp_ld);
    last_load = exp_ld;
    $display("txn %0d ld=%0b st=%0b f3=%0d addr=%h stalls=%0d reqs=%0d err=%0b load_data=%h",
             idx, v.is_load, v.is_store, v.func3, v.addr, stall_n, req_n, err_seen, load_data);
    @(negedge clk);
  endtask

  initial begin
    //          ld  st  f3     addr          wdata         rdata         w     err  exp_addr      exp_wdata     strb  exp_load
    vecs[0]  = '{1'b0, 1'b1, F3_W,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        4'd0, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, F3_B,  32'h0000_0203, 32'h0000_00A5, 32'h0,        4'd0, 1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 4'h8, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, F3_H,  32'h0000_0202, 32'h1234_BEEF, 32'h0,        4'd1, 1'b0, 32'h0000_0200, 32'hBEEF_BEEF, 4'hC, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, F3_B,  32'h0000_0201, 32'h0000_0077, 32'h0,        4'd0, 1'b0, 32'h0000_0200, 32'h7777_7777, 4'h2, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, F3_B,  32'h0000_0302, 32'h0,         32'h12F4_5678, 4'd0, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'hFFFF_FFF4};
    vecs[5]  = '{1'b1, 1'b0, F3_BU, 32'h0000_0302, 32'h0,         32'h12F4_5678, 4'd0, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'h0000_00F4};
    vecs[6]  = '{1'b1, 1'b0, F3_HU, 32'h0000_0302, 32'h0,         32'h12F4_5678, 4'd0, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'h0000_12F4};
    vecs[7]  = '{1'b1, 1'b0, F3_H,  32'h0000_0300, 32'h0,         32'h12F4_8765, 4'd0, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'hFFFF_8765};
    vecs[8]  = '{1'b1, 1'b0, F3_W,  32'h0000_0400, 32'h0,         32'hCAFE_F00D, 4'd3, 1'b0, 32'h0000_0400, 32'h0,        4'h0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 1'b0, F3_B,  32'h0000_0301, 32'h0,         32'h0000_80FF, 4'd0, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'hFFFF_FF80};
    vecs[10] = '{1'b1, 1'b0, F3_BU, 32'h0000_0300, 32'h0,         32'h0000_00FE, 4'd2, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 32'h0000_00FE};
    vecs[11] = '{1'b1, 1'b0, F3_H,  32'h0000_0101, 32'h0,         32'h1111_1111, 4'd0, 1'b1, 32'h0,         32'h0,        4'h0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, F3_W,  32'h0000_0102, 32'h5555_5555, 32'h0,        4'd0, 1'b1, 32'h0,         32'h0,        4'h0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'd3,  32'h0000_0100, 32'h0,         32'h2222_2222, 4'd0, 1'b1, 32'h0,         32'h0,        4'h0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, F3_BU, 32'h0000_0100, 32'h0000_0011, 32'h0,        4'd0, 1'b1, 32'h0,         32'h0,        4'h0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, F3_W,  32'h0000_0100, 32'h0,         32'h3333_3333, 4'd0, 1'b1, 32'h0,         32'h0,        4'h0, 32'h0};

    rst = 1'b1; mem_en = 1'b0; is_mem_load = 1'b0; is_mem_store = 1'b0;
    func3 = 3'd0; addr = 32'h0; wdata = 32'h0; dm.ack = 1'b0; dm.rdata = 32'h0;
    last_load = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", {31'b0, dm.req}, 32'd0);
    chk("rst_we", {31'b0, dm.we}, 32'd0);
    chk("rst_addr", dm.addr, 32'd0);
    chk("rst_wdata", dm.wdata, 32'd0);
    chk("rst_wstrb", {28'b0, dm.wstrb}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_txn(i, vecs[i]);

    // Reset in the second WAIT cycle of a load abandons it.
    mem_en = 1'b1; is_mem_load = 1'b1; is_mem_store = 1'b0;
    func3 = F3_W; addr = 32'h0000_0500; dm.ack = 1'b0; dm.rdata = 32'h9999_9999;
    #1;
    chk("abort_idle_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("abort_wait1_req", {31'b0, dm.req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_wait2_req", {31'b0, dm.req}, 32'd1);
    @(negedge clk);
    rst = 1'b0; mem_en = 1'b0;
    #1;
    chk("abort_req_drop", {31'b0, dm.req}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_load_valid", {31'b0, load_valid}, 32'd0);
    chk("abort_load_data", load_data, 32'd0);
    last_load = 32'h0;
    @(negedge clk); #1;
    chk("abort_idle_req", {31'b0, dm.req}, 32'd0);
    chk("abort_idle_load_valid", {31'b0, load_valid}, 32'd0);
    $display("txn abort: reset in WAIT, req=%0b stall=%0b", dm.req, stall);
    @(negedge clk);
    run_txn(NV, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
